deserializer_db: RTL and testbench
==================================

Name: deserializer_db

Overview:
- Parametrised, double-buffered successor to the fixed-length sample deserializer.
- Collects BIT_WIDTH-bit samples over a val/rdy stream into frames whose length is set at run time (1..N_SAMPLES).
- Presents each frame as a parallel array on a val/rdy output.
- Sits between the serial sample source (ADC/SPI side) and the parallel FFT/classifier input.
- Gains over the previous generation:
  - a second bank, so filling overlaps the downstream stall;
  - runtime frame length;
  - a flush input that closes partial frames.

Parameters:
- N_SAMPLES, 8, maximum samples per frame / number of output lanes (≥2).
- BIT_WIDTH, 32, bits per sample.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_len  input  $clog2(N_SAMPLES)+1  requested frame length; sampled at frame start.
- flush  input  1  close the current partial frame.
- recv_val  input  1  input sample valid.
- recv_rdy  output  1  block can accept a sample.
- recv_msg  input  BIT_WIDTH  input sample.
- send_val  output  1  output frame valid.
- send_rdy  input  1  downstream accepts frame.
- send_msg  output  BIT_WIDTH x N_SAMPLES (unpacked array [N_SAMPLES-1:0])  frame; lane 0 is the first sample.
- send_len  output  $clog2(N_SAMPLES)+1  number of valid lanes in send_msg.

Behaviour:
- Transfer definitions:
  - recv fire = recv_val & recv_rdy;
  - send fire = send_val & send_rdy.
  - Neither side's rdy may depend combinationally on the other side's val.
- Reset (synchronous, reset=1 at an edge):
  - count=0, fill state FILLING, out bank empty;
  - send_val=0, send_msg all lanes 0, send_len=0, recv_rdy=1 in the following cycle.
  - Reset mid-frame discards both banks; no partial frame is emitted.
- Frame length:
  - On the first recv fire of a frame (count==0), or on flush when count==0 is impossible (see below), frame_len <= cfg_len.
  - cfg_len==0 or cfg_len>N_SAMPLES is clamped to N_SAMPLES.
  - cfg_len changes mid-frame have no effect until the next frame.
- Fill FSM, two states:
  - FILLING:
    - recv_rdy=1.
    - On recv fire, fill lane[count] <= recv_msg and count <= count+1.
    - If count+1 == frame_len, go to FULL with fill_len = count+1.
    - flush=1 with no recv fire and count>0: go to FULL with fill_len=count.
    - flush=1 with count==0 and no recv fire: ignored.
    - flush=1 coincident with recv fire: the sample is written, then go to FULL with fill_len=count+1.
  - FULL:
    - recv_rdy=0; flush ignored.
    - If out bank empty, or send fire this cycle: copy fill to out bank, send_len <= fill_len, send_val <= 1, count <= 0, go to FILLING.
- Out bank:
  - send_msg and send_len are held stable while send_val=1 && !send_rdy.
  - On send fire with no simultaneous copy, send_val <= 0; send_msg and send_len are held unchanged.
  - Lanes ≥ send_len read 0: the fill bank is cleared on copy, or lanes are masked at copy.
- Timing:
  - Latency: last sample accepted at edge t → FULL after t → send_val=1 after edge t+1, when the out bank is free.
  - Throughput with send_rdy=1 constantly: one frame per frame_len+1 cycles. The FULL bubble is the only stall.
- Downstream stall:
  - The out bank holds frame k while the fill bank collects frame k+1.
  - recv_rdy drops only when both banks are occupied.
- Widths:
  - count and lengths are $clog2(N_SAMPLES)+1 bits and must represent N_SAMPLES exactly.
  - No wrap; count never exceeds frame_len.

Decomposition:
- Shared package deserializer_pkg:
  - fill-state enum {FILLING, FULL};
  - a localparam function/constant for the length width $clog2(N_SAMPLES)+1.
- Sub-module deserializer_bank (N_SAMPLES x BIT_WIDTH register array):
  - ports: per-lane write enable, clear, and a full-bank load from another bank.
  - Instantiated twice (fill, out), built from the existing vc_EnResetReg.
- The top holds the FSM, counter, length latch and handshake logic.

Test Plan:
- cfg_len=8, send_rdy=1, recv 8 samples 0x10..0x17 back-to-back → recv_rdy low for 1 cycle; send_val after 2 edges; send_msg[0..7]=0x10..0x17, send_len=8.
- cfg_len=3, stream 0xA,0xB,0xC,0xD,0xE,0xF → two frames {A,B,C} then {D,E,F}, send_len=3, lanes 3..7 =0.
- send_rdy=0, cfg_len=4, stream 12 samples → frame 1 held stable in the out bank, frame 2 fills; then recv_rdy=0 until send_rdy=1. Frames arrive in order with no loss or duplication.
- cfg_len=8, 3 samples 1,2,3 then flush alone → frame {1,2,3,0,...}, send_len=3. Flush with count==0 → no frame. Flush with a 5th recv fire → send_len=5.
- cfg_len changes 4→2 after the 1st sample of a frame → current frame length 4, next frame length 2. cfg_len=0 or cfg_len=9 (N_SAMPLES=8) → length 8.
- Assert reset mid-frame with the out bank valid → next cycle send_val=0, send_msg=0, recv_rdy=1. New frame starts at lane 0.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared types and width helpers for the
// double-buffered sample deserializer.
package deserializer_pkg;

   typedef enum logic {
      FILLING = 1'b0,
      FULL    = 1'b1
   } fill_state_e;

   // Length fields must hold N itself, hence the extra bit.
   function automatic int len_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/deserializer_db_if.sv
// Stream-side bundle of the deserializer: sample input,
// frame output and run-time frame controls.
interface deserializer_db_if
   import deserializer_pkg::*;
#(
   parameter int N_SAMPLES = 8,
   parameter int BIT_WIDTH = 32
) ();

   localparam int LW = len_w(N_SAMPLES);

   logic [LW-1:0]        cfg_len;
   logic                 flush;
   logic                 recv_val;
   logic                 recv_rdy;
   logic [BIT_WIDTH-1:0] recv_msg;
   logic                 send_val;
   logic                 send_rdy;
   logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0];
   logic [LW-1:0]        send_len;

   modport slave (
      input  cfg_len, flush,
      input  recv_val, recv_msg, send_rdy,
      output recv_rdy, send_val, send_msg, send_len
   );

   modport master (
      output cfg_len, flush,
      output recv_val, recv_msg, send_rdy,
      input  recv_rdy, send_val, send_msg, send_len
   );

endinterface

// File: rtl/deserializer_bank.sv
// N-lane sample register bank with per-lane write,
// whole-bank clear and whole-bank load.
module deserializer_bank #(
   parameter int N_SAMPLES = 8,
   parameter int BIT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 load,
   input  logic [N_SAMPLES-1:0] we,
   input  logic [BIT_WIDTH-1:0] wdata,
   input  logic [BIT_WIDTH-1:0] load_data [N_SAMPLES-1:0],
   output logic [BIT_WIDTH-1:0] data [N_SAMPLES-1:0]
);

   logic [BIT_WIDTH-1:0] lane_q [N_SAMPLES-1:0];
   logic [BIT_WIDTH-1:0] lane_d [N_SAMPLES-1:0];

   always_comb begin
      for (int i = 0; i < N_SAMPLES; i++) begin
         lane_d[i] = lane_q[i];
         if (clear)
            lane_d[i] = '0;
         else if (load)
            lane_d[i] = load_data[i];
         else if (we[i])
            lane_d[i] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
         if (reset)
            lane_q[i] <= '0;
         else
            lane_q[i] <= lane_d[i];
      end
   end

   assign data = lane_q;

endmodule

// File: rtl/deserializer_db.sv
// Double-buffered deserializer: fill bank collects a frame
// while the out bank presents the previous one downstream.
module deserializer_db
   import deserializer_pkg::*;
#(
   parameter int N_SAMPLES = 8,
   parameter int BIT_WIDTH = 32
) (
   input logic              clk,
   input logic              reset,
   deserializer_db_if.slave io
);

   localparam int LW = len_w(N_SAMPLES);
   localparam logic [LW-1:0] MAX_LEN = LW'(N_SAMPLES);

   fill_state_e   state_q, state_d;
   logic [LW-1:0] count_q, count_d;
   logic [LW-1:0] frame_len_q, frame_len_d;
   logic [LW-1:0] fill_len_q, fill_len_d;
   logic [LW-1:0] send_len_q, send_len_d;
   logic          send_val_q, send_val_d;

   logic          recv_fire, send_fire, copy;
   logic [LW-1:0] cfg_clamped, eff_len, count_inc;
   logic [N_SAMPLES-1:0] we;

   logic [BIT_WIDTH-1:0] fill_data [N_SAMPLES-1:0];
   logic [BIT_WIDTH-1:0] out_data  [N_SAMPLES-1:0];
   logic [BIT_WIDTH-1:0] no_load   [N_SAMPLES-1:0];

   assign cfg_clamped = (io.cfg_len == '0 || io.cfg_len > MAX_LEN)
                      ? MAX_LEN : io.cfg_len;
   // The first sample of a frame must see the new length at once.
   assign eff_len   = (count_q == '0) ? cfg_clamped : frame_len_q;
   assign count_inc = count_q + LW'(1);
   assign recv_fire = io.recv_val && (state_q == FILLING);
   assign send_fire = send_val_q && io.send_rdy;
   assign copy      = (state_q == FULL) && (!send_val_q || send_fire);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      frame_len_d = frame_len_q;
      fill_len_d  = fill_len_q;
      send_len_d  = send_len_q;
      send_val_d  = send_val_q;
      for (int i = 0; i < N_SAMPLES; i++)
         we[i] = recv_fire && (count_q == LW'(i));
      unique case (state_q)
         FILLING: begin
            if (recv_fire) begin
               count_d = count_inc;
               if (count_q == '0)
                  frame_len_d = cfg_clamped;
               if (count_inc == eff_len || io.flush) begin
                  state_d    = FULL;
                  fill_len_d = count_inc;
               end
            end else if (io.flush && count_q != '0) begin
               state_d    = FULL;
               fill_len_d = count_q;
            end
         end
         FULL: begin
            if (copy) begin
               state_d    = FILLING;
               count_d    = '0;
               send_len_d = fill_len_q;
               send_val_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (send_fire && !copy)
         send_val_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FILLING;
         count_q     <= '0;
         frame_len_q <= MAX_LEN;
         fill_len_q  <= '0;
         send_len_q  <= '0;
         send_val_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         frame_len_q <= frame_len_d;
         fill_len_q  <= fill_len_d;
         send_len_q  <= send_len_d;
         send_val_q  <= send_val_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N_SAMPLES; i++)
         no_load[i] = '0;
   end

   // Clearing the fill bank on copy keeps unused lanes at zero.
   deserializer_bank #(
      .N_SAMPLES(N_SAMPLES),
      .BIT_WIDTH(BIT_WIDTH)
   ) u_fill (
      .clk      (clk),
      .reset    (reset),
      .clear    (copy),
      .load     (1'b0),
      .we       (we),
      .wdata    (io.recv_msg),
      .load_data(no_load),
      .data     (fill_data)
   );

   deserializer_bank #(
      .N_SAMPLES(N_SAMPLES),
      .BIT_WIDTH(BIT_WIDTH)
   ) u_out (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .load     (copy),
      .we       ('0),
      .wdata    ('0),
      .load_data(fill_data),
      .data     (out_data)
   );

   assign io.recv_rdy = (state_q == FILLING);
   assign io.send_val = send_val_q;
   assign io.send_len = send_len_q;
   assign io.send_msg = out_data;

endmodule

// File: tb/tb_deserializer_db.sv
// Bench for deserializer_db: vector table, directed corner
// sequences and random traffic against a frame-queue model.
module tb_deserializer_db;
   import deserializer_pkg::*;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int LW = len_w(N);

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   deserializer_db_if #(.N_SAMPLES(N), .BIT_WIDTH(W)) io ();

   deserializer_db #(.N_SAMPLES(N), .BIT_WIDTH(W)) dut (
      .clk  (clk),
      .reset(reset),
      .io   (io)
   );

   typedef struct {
      int len;
      logic [N-1:0][W-1:0] d;
   } frame_t;

   typedef struct {
      int cfg;
      int nsamp;
      int fl;
      int exp_len;
   } vec_t;

   int errors = 0;
   int checks = 0;

   frame_t       exp_q [$];
   logic [W-1:0] cur [$];
   int           cur_len = 0;
   bit           closed_wait = 0;
   bit           out_occ = 0;
   bit           mon_en = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, req, $time);
      end
   endtask

   function automatic int clamp(input int c);
      return (c == 0 || c > N) ? N : c;
   endfunction

   // Frame-level model: closed frames queue up in order; one may
   // wait behind the out bank, and only then does intake stop.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         cur.delete();
         cur_len = 0;
         closed_wait = 0;
         out_occ = 0;
      end else if (mon_en) begin
         bit rdy;
         bit sfire;
         bit close;
         int bad;
         frame_t f;
         rdy = !closed_wait;
         check("recv_rdy", io.recv_rdy, rdy);
         check("send_val", io.send_val, out_occ);
         sfire = out_occ && io.send_rdy;
         if (sfire) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL frame: got unexpected frame expected none");
            end else begin
               f = exp_q.pop_front();
               check("frame_len", io.send_len, f.len);
               bad = -1;
               for (int i = N - 1; i >= 0; i--)
                  if (io.send_msg[i] !== f.d[i]) bad = i;
               if (bad < 0)
                  check("frame_msg", 0, 0 + (io.send_msg[0] !== f.d[0]));
               else
                  check($sformatf("frame_msg[%0d]", bad),
                        io.send_msg[bad], f.d[bad]);
            end
         end
         if (closed_wait && (!out_occ || sfire)) begin
            out_occ = 1;
            closed_wait = 0;
         end else if (sfire) begin
            out_occ = 0;
         end
         if (rdy) begin
            close = 0;
            if (io.recv_val) begin
               if (cur.size() == 0) cur_len = clamp(int'(io.cfg_len));
               cur.push_back(io.recv_msg);
               close = (cur.size() == cur_len) || io.flush;
            end else begin
               close = io.flush && (cur.size() > 0);
            end
            if (close) begin
               f.len = cur.size();
               f.d = '0;
               foreach (cur[i]) f.d[i] = cur[i];
               exp_q.push_back(f);
               cur.delete();
               closed_wait = 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic push(input logic [W-1:0] m);
      int n = 0;
      bit r = 0;
      io.recv_val = 1'b1;
      io.recv_msg = m;
      do begin
         r = io.recv_rdy;
         step();
         n++;
      end while (!r && n < 50);
      if (!r) begin
         checks++;
         errors++;
         $display("FAIL push: got no recv_rdy expected accept in 50 cycles");
      end
      io.recv_val = 1'b0;
   endtask

   task automatic wait_send(input string name, input int len,
                            input logic [N-1:0][W-1:0] d);
      int n = 0;
      while (!io.send_val && n < 50) begin
         step();
         n++;
      end
      check({name, "_val"}, io.send_val, 1);
      check({name, "_len"}, io.send_len, len);
      for (int i = 0; i < N; i++)
         check($sformatf("%s_lane%0d", name, i), io.send_msg[i], d[i]);
      step();
   endtask

   task automatic check_idle(input string name);
      check({name, "_val"}, io.send_val, 0);
      check({name, "_len"}, io.send_len, 0);
      check({name, "_rdy"}, io.recv_rdy, 1);
      for (int i = 0; i < N; i++)
         check($sformatf("%s_lane%0d", name, i), io.send_msg[i], 0);
   endtask

   vec_t tbl [10];
   logic [N-1:0][W-1:0] e;

   initial begin
      tbl[0] = '{8, 8, 0, 8};
      tbl[1] = '{3, 3, 0, 3};
      tbl[2] = '{0, 8, 0, 8};
      tbl[3] = '{9, 8, 0, 8};
      tbl[4] = '{15, 8, 0, 8};
      tbl[5] = '{1, 1, 0, 1};
      tbl[6] = '{8, 3, 2, 3};
      tbl[7] = '{8, 5, 1, 5};
      tbl[8] = '{2, 2, 0, 2};
      tbl[9] = '{6, 2, 2, 2};

      io.cfg_len  = LW'(8);
      io.flush    = 1'b0;
      io.recv_val = 1'b0;
      io.recv_msg = '0;
      io.send_rdy = 1'b1;
      reset = 1'b1;
      step();
      step();
      check_idle("reset");
      reset = 1'b0;
      mon_en = 1;

      for (int r = 0; r < 10; r++) begin
         do_reset();
         io.cfg_len = LW'(tbl[r].cfg);
         e = '0;
         for (int i = 0; i < tbl[r].nsamp; i++) begin
            if (tbl[r].fl == 1 && i == tbl[r].nsamp - 1) io.flush = 1'b1;
            push(32'h1000 * r + i);
            io.flush = 1'b0;
            if (i < tbl[r].exp_len) e[i] = 32'h1000 * r + i;
         end
         if (tbl[r].fl == 2) begin
            io.flush = 1'b1;
            step();
            io.flush = 1'b0;
         end
         wait_send($sformatf("vec%0d", r), tbl[r].exp_len, e);
      end

      // Full-length frame timing: one bubble, send_val one edge later.
      do_reset();
      io.cfg_len = LW'(8);
      e = '0;
      for (int i = 0; i < 8; i++) begin
         push(32'h10 + i);
         e[i] = 32'h10 + i;
      end
      check("t1_rdy_bubble", io.recv_rdy, 0);
      check("t1_val_early", io.send_val, 0);
      step();
      check("t1_rdy_back", io.recv_rdy, 1);
      wait_send("t1", 8, e);

      do_reset();
      io.cfg_len = LW'(3);
      e = '0;
      e[0] = 32'hA; e[1] = 32'hB; e[2] = 32'hC;
      push(32'hA); push(32'hB); push(32'hC);
      wait_send("t2a", 3, e);
      e[0] = 32'hD; e[1] = 32'hE; e[2] = 32'hF;
      push(32'hD); push(32'hE); push(32'hF);
      wait_send("t2b", 3, e);

      // Flush with nothing collected produces no frame.
      do_reset();
      io.flush = 1'b1;
      step();
      step();
      io.flush = 1'b0;
      repeat (4) step();
      check("flush_empty_val", io.send_val, 0);

      do_reset();
      io.cfg_len = LW'(4);
      push(32'h1);
      io.cfg_len = LW'(2);
      push(32'h2); push(32'h3); push(32'h4);
      e = '0;
      e[0] = 1; e[1] = 2; e[2] = 3; e[3] = 4;
      wait_send("cfg_old", 4, e);
      push(32'h5); push(32'h6);
      e = '0;
      e[0] = 5; e[1] = 6;
      wait_send("cfg_new", 2, e);

      // Both banks full under a stalled sink.
      do_reset();
      io.send_rdy = 1'b0;
      io.cfg_len = LW'(4);
      for (int i = 1; i <= 8; i++) push(32'h300 + i);
      repeat (3) step();
      check("stall_rdy", io.recv_rdy, 0);
      check("stall_len", io.send_len, 4);
      check("stall_lane0", io.send_msg[0], 32'h301);
      io.send_rdy = 1'b1;
      for (int i = 9; i <= 12; i++) push(32'h300 + i);
      repeat (10) step();
      check("stall_drain", exp_q.size(), 0);

      do_reset();
      io.send_rdy = 1'b0;
      io.cfg_len = LW'(2);
      push(32'h21); push(32'h22); push(32'h23);
      step();
      check("mid_val_pre", io.send_val, 1);
      do_reset();
      check_idle("mid_reset");
      io.send_rdy = 1'b1;
      io.cfg_len = LW'(1);
      e = '0;
      e[0] = 32'h55;
      push(32'h55);
      wait_send("mid_new", 1, e);

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         io.recv_val = ($urandom_range(0, 9) < 7);
         io.recv_msg = $urandom;
         if (c < 1000)
            io.send_rdy = ($urandom_range(0, 3) != 0);
         else if (c < 2000)
            io.send_rdy = ($urandom_range(0, 3) == 0);
         else
            io.send_rdy = 1'b1;
         io.flush = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0)
            io.cfg_len = LW'($urandom_range(0, 15));
         step();
      end
      io.recv_val = 1'b0;
      io.flush = 1'b0;
      io.send_rdy = 1'b1;
      repeat (20) step();
      check("rand_drain", exp_q.size(), 0);
      check("rand_idle", io.send_val, 0);

      mon_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
